// File: rtl/tabla_programable.sv
// Programmable registered truth table: row-at-a-time writes, 1-cycle evaluate,
// and a sweep mode that streams every row and counts channel-0 minterms.
module tabla_programable #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [N_IN-1:0]  wr_addr,
    input  logic [N_OUT-1:0] wr_data,
    output logic             wr_ready,
    input  logic             eval_valid,
    input  logic [N_IN-1:0]  eval_in,
    output logic [N_OUT-1:0] eval_out,
    output logic             eval_out_valid,
    input  logic             sweep_start,
    output logic             sweep_busy,
    output logic             sweep_valid,
    output logic [N_IN-1:0]  sweep_addr,
    output logic [N_OUT-1:0] sweep_data,
    output logic             sweep_done,
    output logic [N_IN:0]    ones_count
);

    localparam int unsigned DEPTH = 1 << N_IN;

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    state_t           state_q, state_d;
    logic [N_OUT-1:0] table_q [DEPTH];
    logic [N_IN-1:0]  cnt_q;
    logic [N_IN:0]    ones_q;
    logic [N_OUT-1:0] eval_q;
    logic             eval_v_q;
    logic             cnt_last;

    assign cnt_last = (cnt_q == {N_IN{1'b1}});

    always_comb begin
        state_d     = state_q;
        sweep_busy  = 1'b0;
        sweep_valid = 1'b0;
        sweep_done  = 1'b0;
        sweep_addr  = '0;
        sweep_data  = '0;
        case (state_q)
            IDLE: begin
                if (sweep_start) state_d = SWEEP;
            end
            SWEEP: begin
                sweep_busy  = 1'b1;
                sweep_valid = 1'b1;
                sweep_addr  = cnt_q;
                sweep_data  = table_q[cnt_q];
                if (cnt_last) state_d = DONE;
            end
            DONE: begin
                sweep_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr_ready       = ~sweep_busy;
    assign eval_out       = eval_q;
    assign eval_out_valid = eval_v_q;
    assign ones_count     = ones_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ones_q   <= '0;
            eval_q   <= '0;
            eval_v_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) table_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            eval_v_q <= eval_valid;
            // Read uses the pre-edge table, so a same-row write is not visible yet.
            if (eval_valid) eval_q <= table_q[eval_in];
            if (wr_en && wr_ready) table_q[wr_addr] <= wr_data;
            if (state_q == IDLE && sweep_start) begin
                cnt_q  <= '0;
                ones_q <= '0;
            end else if (state_q == SWEEP) begin
                if (table_q[cnt_q][0]) ones_q <= ones_q + (N_IN+1)'(1);
                // Hold on the last row so the counter never starts a second pass.
                if (!cnt_last) cnt_q <= cnt_q + N_IN'(1);
            end
        end
    end

endmodule

// File: tb/tb_tabla_programable.sv
// Self-checking bench for tabla_programable: vector table, directed sweeps,
// and randomized write/evaluate traffic against an array model of the table.
module tb_tabla_programable;

    localparam int NI = 4;
    localparam int NO = 2;
    localparam int D  = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_en = 1'b0;
    logic [NI-1:0] wr_addr = '0;
    logic [NO-1:0] wr_data = '0;
    logic          wr_ready;
    logic          eval_valid = 1'b0;
    logic [NI-1:0] eval_in = '0;
    logic [NO-1:0] eval_out;
    logic          eval_out_valid;
    logic          sweep_start = 1'b0;
    logic          sweep_busy;
    logic          sweep_valid;
    logic [NI-1:0] sweep_addr;
    logic [NO-1:0] sweep_data;
    logic          sweep_done;
    logic [NI:0]   ones_count;

    always #5 clk = ~clk;

    tabla_programable #(.N_IN(NI), .N_OUT(NO)) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .eval_valid(eval_valid), .eval_in(eval_in),
        .eval_out(eval_out), .eval_out_valid(eval_out_valid),
        .sweep_start(sweep_start), .sweep_busy(sweep_busy), .sweep_valid(sweep_valid),
        .sweep_addr(sweep_addr), .sweep_data(sweep_data), .sweep_done(sweep_done),
        .ones_count(ones_count)
    );

    int total = 0;
    int bad   = 0;
    logic [NO-1:0] mdl [D];

    typedef struct {
        bit          we;
        logic [3:0]  wa;
        logic [1:0]  wd;
        bit          ev;
        logic [3:0]  ei;
        logic [1:0]  exp_out;
        bit          exp_v;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int bit0_ones();
        int n = 0;
        for (int r = 0; r < D; r++) if (mdl[r][0]) n++;
        return n;
    endfunction

    task automatic write_row(input int a, input logic [NO-1:0] d);
        wr_en = 1'b1; wr_addr = NI'(a); wr_data = d;
        tick();
        wr_en = 1'b0;
        mdl[a] = d;
    endtask

    // Full sweep with concurrent evaluates; optionally a blocked write and a restart attempt.
    task automatic do_sweep(input bit try_write, input bit try_restart);
        int ones;
        int pend_ev;
        logic [NO-1:0] pend_exp;
        ones = bit0_ones();
        pend_ev = 0;
        pend_exp = '0;
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        for (int r = 0; r < D; r++) begin
            chk("sweep_valid", sweep_valid, 1);
            chk("sweep_busy", sweep_busy, 1);
            chk("wr_ready_busy", wr_ready, 0);
            chk("sweep_addr", sweep_addr, r);
            chk("sweep_data", sweep_data, mdl[r]);
            chk("sweep_done_early", sweep_done, 0);
            if (pend_ev != 0) chk("eval_in_sweep", eval_out, pend_exp);
            eval_valid = 1'b1;
            eval_in = NI'($urandom % D);
            pend_exp = mdl[eval_in];
            pend_ev = 1;
            wr_en = (try_write && r == 2);
            wr_addr = 4'd3;
            wr_data = '1;
            sweep_start = (try_restart && r == 5);
            tick();
        end
        eval_valid = 1'b0; wr_en = 1'b0; sweep_start = 1'b0;
        chk("eval_in_sweep_last", eval_out, pend_exp);
        chk("done_pulse", sweep_done, 1);
        chk("done_valid", sweep_valid, 0);
        chk("done_busy", sweep_busy, 0);
        chk("done_wr_ready", wr_ready, 1);
        chk("ones_count", ones_count, ones);
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        chk("after_done_pulse", sweep_done, 0);
        chk("start_in_done_ignored", sweep_busy, 0);
        chk("ones_hold", ones_count, ones);
        tick();
        chk("ones_hold2", ones_count, ones);
        chk("idle_busy", sweep_busy, 0);
    endtask

    initial begin
        vec_t vecs [9];
        logic [NO-1:0] last_out;
        logic [15:0] parity;
        int done_seen;

        vecs[0] = '{1, 4'd5,  2'd1, 1, 4'd5,  2'd0, 1};
        vecs[1] = '{0, 4'd0,  2'd0, 1, 4'd5,  2'd1, 1};
        vecs[2] = '{0, 4'd0,  2'd0, 0, 4'd0,  2'd1, 0};
        vecs[3] = '{1, 4'd10, 2'd2, 1, 4'd0,  2'd0, 1};
        vecs[4] = '{0, 4'd0,  2'd0, 1, 4'd10, 2'd2, 1};
        vecs[5] = '{1, 4'd10, 2'd3, 1, 4'd10, 2'd2, 1};
        vecs[6] = '{0, 4'd0,  2'd0, 1, 4'd10, 2'd3, 1};
        vecs[7] = '{1, 4'd5,  2'd0, 0, 4'd0,  2'd3, 0};
        vecs[8] = '{0, 4'd0,  2'd0, 1, 4'd5,  2'd0, 1};

        for (int r = 0; r < D; r++) mdl[r] = '0;

        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_eval_out", eval_out, 0);
        chk("rst_eval_valid", eval_out_valid, 0);
        chk("rst_busy", sweep_busy, 0);
        chk("rst_valid", sweep_valid, 0);
        chk("rst_addr", sweep_addr, 0);
        chk("rst_data", sweep_data, 0);
        chk("rst_done", sweep_done, 0);
        chk("rst_ones", ones_count, 0);

        do_sweep(0, 0);
        chk("empty_ones", ones_count, 0);

        for (int i = 0; i < 9; i++) begin
            wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
            eval_valid = vecs[i].ev; eval_in = vecs[i].ei;
            tick();
            chk($sformatf("vec%0d_valid", i), eval_out_valid, vecs[i].exp_v);
            chk($sformatf("vec%0d_out", i), eval_out, vecs[i].exp_out);
            if (vecs[i].we) mdl[vecs[i].wa] = vecs[i].wd;
        end
        wr_en = 1'b0; eval_valid = 1'b0;

        parity = 16'h6996;
        for (int r = 0; r < D; r++) write_row(r, {1'($urandom % 2), parity[r]});
        do_sweep(1, 1);
        chk("parity_ones", ones_count, 8);
        eval_valid = 1'b1; eval_in = 4'd3;
        tick();
        eval_valid = 1'b0;
        chk("dropped_write_row3", eval_out, mdl[3]);
        chk("dropped_write_row3_bit0", eval_out[0], 0);

        for (int r = 0; r < D; r++) write_row(r, '1);
        do_sweep(0, 0);
        chk("all_ones", ones_count, 5'b10000);

        last_out = eval_out;
        for (int round = 0; round < 3; round++) begin
            for (int n = 0; n < 120; n++) begin
                logic [NO-1:0] exp_e;
                wr_en = 1'($urandom % 2);
                wr_addr = NI'($urandom % D);
                wr_data = NO'($urandom);
                eval_valid = 1'($urandom % 2);
                eval_in = NI'($urandom % D);
                exp_e = eval_valid ? mdl[eval_in] : last_out;
                tick();
                chk("rand_valid", eval_out_valid, eval_valid);
                chk("rand_out", eval_out, exp_e);
                last_out = exp_e;
                if (wr_en) mdl[wr_addr] = wr_data;
            end
            wr_en = 1'b0; eval_valid = 1'b0;
            do_sweep(round == 1, round == 2);
            last_out = eval_out;
        end

        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        chk("abort_at_row7", sweep_addr, 7);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int r = 0; r < D; r++) mdl[r] = '0;
        chk("abort_busy", sweep_busy, 0);
        chk("abort_ones", ones_count, 0);
        chk("abort_wr_ready", wr_ready, 1);
        done_seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (sweep_done) done_seen++;
            tick();
        end
        chk("abort_no_done", done_seen, 0);
        for (int r = 0; r < D; r++) begin
            eval_valid = 1'b1; eval_in = NI'(r);
            tick();
            chk("abort_row_zero", eval_out, 0);
        end
        eval_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
